// File: rtl/dm_pkg.sv
// Package dm: shared DMI types for the DTM-side access controller.
//   dtm_op_e     - JTAG dmi op field (NOP / READ / WRITE)
//   dmi_req_t    - request toward the debug module {addr[6:0], op[1:0], data[31:0]}
//   dmi_resp_t   - response from the debug module {data[31:0], resp[1:0]}
//   dmi_error_e  - sticky dmistat encoding reported through dtmcs
//   dmi_state_e  - controller states
//   DmiTimeoutCycles - response timeout, used only when DMI_RESP_TIMEOUT_EN is defined
package dm;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    DmiNoError  = 2'h0,
    DmiReserved = 2'h1,
    DmiOpFailed = 2'h2,
    DmiBusy     = 2'h3
  } dmi_error_e;

  typedef enum logic [2:0] {
    Idle           = 3'd0,
    Read           = 3'd1,
    WaitReadValid  = 3'd2,
    Write          = 3'd3,
    WaitWriteValid = 3'd4
  } dmi_state_e;

  localparam int unsigned DmiTimeoutCycles = 255;

endpackage

// File: rtl/dmi_access_ctrl.sv
// dmi_access_ctrl: converts JTAG dmi capture/update pulses into DMI request /
// response transactions toward the debug module and keeps the sticky dmistat.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   dmi_capture_i            capture-DR pulse for the dmi register
//   dmi_update_i             update-DR pulse for the dmi register
//   dmi_wdata_i[40:0]        shifted-in {addr[6:0], data[31:0], op[1:0]}
//   dmi_rdata_o[40:0]        capture value {addr_q, data_q, status}
//   dmireset_i               clears the sticky error
//   dmihardreset_i           aborts the transaction and clears the error
//   dmistat_o                current sticky error
//   idle_o[2:0]              IdleCycles, for dtmcs.idle
//   dmi_req_valid_o/_ready_i/dmi_req_o     request channel
//   dmi_resp_valid_i/_ready_o/dmi_resp_i   response channel
//
// Optional feature: define DMI_RESP_TIMEOUT_EN to abandon a transaction when no
// response arrives within dm::DmiTimeoutCycles cycles of entering a Wait state.
module dmi_access_ctrl
  import dm::*;
#(
  parameter int unsigned IdleCycles = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmi_capture_i,
  input  logic        dmi_update_i,
  input  logic [40:0] dmi_wdata_i,
  output logic [40:0] dmi_rdata_o,
  input  logic        dmireset_i,
  input  logic        dmihardreset_i,
  output dmi_error_e  dmistat_o,
  output logic [2:0]  idle_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output dmi_req_t    dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  dmi_resp_t   dmi_resp_i
);

  dmi_state_e  state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  dmi_error_e  error_q, error_d;

  logic [6:0]  wdata_addr;
  logic [31:0] wdata_data;
  logic [1:0]  wdata_op;
  logic        busy;
  logic        waiting;
  dmi_error_e  update_error;
  dmi_error_e  status;

  assign wdata_addr = dmi_wdata_i[40:34];
  assign wdata_data = dmi_wdata_i[33:2];
  assign wdata_op   = dmi_wdata_i[1:0];

  assign busy    = (state_q != Idle);
  assign waiting = (state_q == WaitReadValid) || (state_q == WaitWriteValid);

  // A dmireset arriving with the update clears the error first, so the update
  // is judged against the cleared value.
  assign update_error = dmireset_i ? DmiNoError : error_q;

`ifdef DMI_RESP_TIMEOUT_EN
  logic [7:0] timeout_cnt_q, timeout_cnt_d;
  logic       timeout_hit;

  // Counts only while waiting; any non-Wait cycle zeroes it, so every entry
  // into a Wait state starts from 0.
  assign timeout_cnt_d = waiting ? timeout_cnt_q + 8'd1 : 8'd0;
  assign timeout_hit   = (timeout_cnt_q == 8'(DmiTimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_cnt_q <= 8'd0;
    end else begin
      timeout_cnt_q <= timeout_cnt_d;
    end
  end
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    data_d           = data_q;
    error_d          = error_q;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b1;

    // Debugger touched dmi before the previous access finished.
    if (busy && (dmi_update_i || dmi_capture_i) && (error_q == DmiNoError)) begin
      error_d = DmiBusy;
    end

    case (state_q)
      Idle: begin
        if (dmi_update_i && (update_error == DmiNoError)) begin
          if (wdata_op == DTM_READ) begin
            addr_d  = wdata_addr;
            state_d = Read;
          end else if (wdata_op == DTM_WRITE) begin
            addr_d  = wdata_addr;
            data_d  = wdata_data;
            state_d = Write;
          end
        end
      end
      Read, Write: begin
        dmi_req_valid_o  = 1'b1;
        dmi_resp_ready_o = 1'b0;
        if (dmi_req_ready_i) begin
          state_d = (state_q == Read) ? WaitReadValid : WaitWriteValid;
        end
      end
      WaitReadValid, WaitWriteValid: begin
        if (dmi_resp_valid_i) begin
          if (state_q == WaitReadValid) begin
            data_d = dmi_resp_i.data;
          end
          if (dmi_resp_i.resp != DTM_SUCCESS) begin
            error_d = DmiOpFailed;
          end
          state_d = Idle;
        end else if (timeout_hit) begin
          error_d = DmiOpFailed;
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase

    if (dmireset_i) begin
      error_d = DmiNoError;
    end
    if (dmihardreset_i) begin
      state_d = Idle;
      error_d = DmiNoError;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      addr_q  <= 7'd0;
      data_q  <= 32'd0;
      error_q <= DmiNoError;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  // Request fields come straight from registers, so they cannot move while
  // valid is waiting for ready.
  always_comb begin
    dmi_req_o      = '0;
    dmi_req_o.addr = addr_q;
    dmi_req_o.op   = (state_q == Write) ? DTM_WRITE : DTM_READ;
    dmi_req_o.data = (state_q == Write) ? data_q : 32'd0;
  end

  assign status      = (busy && (error_q == DmiNoError)) ? DmiBusy : error_q;
  assign dmi_rdata_o = {addr_q, data_q, status};
  assign dmistat_o   = error_q;
  assign idle_o      = 3'(IdleCycles);

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Testbench for dmi_access_ctrl: directed scenarios plus randomized dmi
// accesses; expected requests and capture values are queued by the stimulus
// and compared by a separate negedge monitor.
module tb_dmi_access_ctrl;
  import dm::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dmi_capture_i = 1'b0;
  logic        dmi_update_i = 1'b0;
  logic [40:0] dmi_wdata_i = '0;
  logic [40:0] dmi_rdata_o;
  logic        dmireset_i = 1'b0;
  logic        dmihardreset_i = 1'b0;
  dmi_error_e  dmistat_o;
  logic [2:0]  idle_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i = 1'b0;
  dmi_req_t    dmi_req_o;
  logic        dmi_resp_valid_i = 1'b0;
  logic        dmi_resp_ready_o;
  dmi_resp_t   dmi_resp_i = '0;

  dmi_access_ctrl #(.IdleCycles(1)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .dmi_capture_i    (dmi_capture_i),
    .dmi_update_i     (dmi_update_i),
    .dmi_wdata_i      (dmi_wdata_i),
    .dmi_rdata_o      (dmi_rdata_o),
    .dmireset_i       (dmireset_i),
    .dmihardreset_i   (dmihardreset_i),
    .dmistat_o        (dmistat_o),
    .idle_o           (idle_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_i       (dmi_resp_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [40:0] exp_req_q[$];
  logic [40:0] exp_cap_q[$];

  // Reference model: what the debugger should observe.
  logic [6:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_err  = 2'd0;
  bit          m_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: compares every request handshake and every capture.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (dmi_req_valid_o && dmi_req_ready_i) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got %h expected no request", dmi_req_o);
        end else begin
          logic [40:0] e;
          e = exp_req_q.pop_front();
          check("req_fields", 64'(dmi_req_o), 64'(e));
          $display("req  addr=%h op=%0d data=%h", dmi_req_o.addr, dmi_req_o.op, dmi_req_o.data);
        end
      end
      if (dmi_capture_i) begin
        if (exp_cap_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_capture: got %h expected none", dmi_rdata_o);
        end else begin
          logic [40:0] c;
          c = exp_cap_q.pop_front();
          check("capture", 64'(dmi_rdata_o), 64'(c));
          $display("cap  addr=%h data=%h status=%0d", dmi_rdata_o[40:34], dmi_rdata_o[33:2], dmi_rdata_o[1:0]);
        end
      end
    end
  end

  task automatic do_capture();
    logic [1:0] st;
    st = (m_busy && m_err == 2'd0) ? 2'd3 : m_err;
    exp_cap_q.push_back({m_addr, m_data, st});
    dmi_capture_i = 1'b1;
    tick();
    dmi_capture_i = 1'b0;
    if (m_busy && m_err == 2'd0) m_err = 2'd3;
  endtask

  task automatic do_dmireset();
    dmireset_i = 1'b1;
    tick();
    dmireset_i = 1'b0;
    m_err = 2'd0;
    check("dmistat_after_dmireset", 64'(dmistat_o), 64'd0);
  endtask

  // One debugger update plus the DM side of the transaction it should cause.
  task automatic run_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                         input int rdy_dly, input int resp_dly, input logic [1:0] code,
                         input logic [31:0] rdata, input bit poke, input bit with_rst);
    bit acc;
    logic [40:0] e;
    if (with_rst) m_err = 2'd0;
    acc = (m_err == 2'd0) && (op == 2'd1 || op == 2'd2);
    dmi_wdata_i  = {addr, data, op};
    dmi_update_i = 1'b1;
    dmireset_i   = with_rst;
    tick();
    dmi_update_i = 1'b0;
    dmireset_i   = 1'b0;
    if (!acc) begin
      // Ready held high so any spurious request would handshake and be flagged.
      dmi_req_ready_i = 1'b1;
      check("no_req_valid", 64'(dmi_req_valid_o), 64'd0);
      tick();
      check("no_req_valid", 64'(dmi_req_valid_o), 64'd0);
      tick();
      dmi_req_ready_i = 1'b0;
      check("dmistat_ignored", 64'(dmistat_o), 64'(m_err));
      return;
    end
    m_addr = addr;
    if (op == 2'd2) m_data = data;
    m_busy = 1'b1;
    e = {addr, op, (op == 2'd1) ? 32'h0 : data};
    check("req_valid_latency", 64'(dmi_req_valid_o), 64'd1);
    for (int i = 0; i < rdy_dly; i++) begin
      check("req_stable", 64'({dmi_req_valid_o, dmi_resp_ready_o, dmi_req_o}), 64'({1'b1, 1'b0, e}));
      tick();
    end
    exp_req_q.push_back(e);
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    check("resp_ready_wait", 64'(dmi_resp_ready_o), 64'd1);
    if (poke) begin
      dmi_wdata_i  = {7'h7f, 32'hdead_beef, 2'd2};
      dmi_update_i = 1'b1;
      tick();
      dmi_update_i = 1'b0;
      if (m_err == 2'd0) m_err = 2'd3;
      check("dmistat_busy", 64'(dmistat_o), 64'(m_err));
    end
    repeat (resp_dly) tick();
    dmi_resp_i       = {rdata, code};
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
    m_busy = 1'b0;
    if (op == 2'd1) m_data = rdata;
    if (code != 2'd0) m_err = 2'd2;
    check("dmistat_after_resp", 64'(dmistat_o), 64'(m_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset behaviour.
    tick();
    tick();
    check("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
    check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
    check("rst_dmistat", 64'(dmistat_o), 64'd0);
    check("rst_rdata", 64'(dmi_rdata_o), 64'd0);
    check("idle_o", 64'(idle_o), 64'd1);
    rst_ni = 1'b1;
    tick();

    // Read 0x11, DM returns 0x0040_0382 at minimum latency.
    run_txn(2'd1, 7'h11, 32'h0, 0, 0, 2'd0, 32'h0040_0382, 1'b0, 1'b0);
    do_capture();

    // Write 0x8000_0001 to 0x10 with ready low for 5 cycles.
    run_txn(2'd2, 7'h10, 32'h8000_0001, 5, 1, 2'd0, 32'h0, 1'b0, 1'b0);
    do_capture();

    // Update while waiting for a read response -> busy error, then ignored.
    run_txn(2'd1, 7'h05, 32'h0, 1, 2, 2'd0, 32'h0000_1234, 1'b1, 1'b0);
    do_capture();
    run_txn(2'd1, 7'h06, 32'h0, 0, 0, 2'd0, 32'h0, 1'b0, 1'b0);
    do_dmireset();
    run_txn(2'd1, 7'h07, 32'h0, 0, 1, 2'd0, 32'hcafe_f00d, 1'b0, 1'b0);
    do_capture();

    // Failing write response: sticky op-failed, update ignored, then
    // dmireset together with an update is accepted.
    run_txn(2'd2, 7'h20, 32'h1111_2222, 0, 0, 2'd2, 32'h0, 1'b0, 1'b0);
    run_txn(2'd2, 7'h21, 32'h3333_4444, 0, 0, 2'd0, 32'h0, 1'b0, 1'b0);
    do_capture();
    run_txn(2'd1, 7'h22, 32'h0, 0, 0, 2'd0, 32'h5555_6666, 1'b0, 1'b1);
    do_capture();

    // Hardreset while the request is pending with ready low.
    dmi_wdata_i  = {7'h33, 32'h0, 2'd1};
    dmi_update_i = 1'b1;
    tick();
    dmi_update_i = 1'b0;
    m_addr = 7'h33;
    m_busy = 1'b1;
    do_capture();
    check("dmistat_busy_capture", 64'(dmistat_o), 64'd3);
    dmihardreset_i = 1'b1;
    tick();
    dmihardreset_i = 1'b0;
    m_err  = 2'd0;
    m_busy = 1'b0;
    check("hardreset_valid", 64'(dmi_req_valid_o), 64'd0);
    check("hardreset_dmistat", 64'(dmistat_o), 64'd0);
    do_capture();

    // Randomized accesses.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  op, code;
      logic [6:0]  addr;
      logic [31:0] data, rdata;
      int          rd, sd;
      bit          poke, wr;
      op    = 2'($urandom_range(0, 3));
      addr  = 7'($urandom);
      data  = $urandom;
      rdata = $urandom;
      rd    = int'($urandom_range(0, 3));
      sd    = int'($urandom_range(0, 3));
      code  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      poke  = ($urandom_range(0, 5) == 0);
      wr    = (m_err != 2'd0) && ($urandom_range(0, 2) == 0);
      run_txn(op, addr, data, rd, sd, code, rdata, poke, wr);
      if ($urandom_range(0, 1) == 1) do_capture();
      if (m_err != 2'd0 && $urandom_range(0, 3) == 0) do_dmireset();
    end

`ifdef DMI_RESP_TIMEOUT_EN
    begin
      logic [31:0] keep;
      if (m_err != 2'd0) do_dmireset();
      keep = m_data;
      dmi_wdata_i  = {7'h44, 32'h0, 2'd1};
      dmi_update_i = 1'b1;
      tick();
      dmi_update_i = 1'b0;
      m_addr = 7'h44;
      exp_req_q.push_back({7'h44, 2'd1, 32'h0});
      dmi_req_ready_i = 1'b1;
      tick();
      dmi_req_ready_i = 1'b0;
      repeat (254) tick();
      check("timeout_not_yet", 64'(dmistat_o), 64'd0);
      tick();
      check("timeout_err", 64'(dmistat_o), 64'd2);
      m_err = 2'd2;
      repeat (44) tick();
      dmi_resp_i       = {32'hffff_0000, 2'd0};
      dmi_resp_valid_i = 1'b1;
      tick();
      dmi_resp_valid_i = 1'b0;
      m_data = keep;
      do_capture();
    end
`endif

    tick();
    tick();
    check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
    check("cap_queue_drained", 64'(exp_cap_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmi_access_ctrl.md
# dmi_access_ctrl

DTM-side DMI access controller. It turns capture/update pulses from the JTAG `dmi` data register into `dm::dmi_req_t` transactions toward the debug module, collects the `dm::dmi_resp_t`, and returns read data and status for the next capture. It keeps the sticky `dmistat` error state reported through `dtmcs`. It sits directly upstream of the debug module's DMI port, in the same clock domain.

## Interface
Parameters:
- `IdleCycles`, default 1: value advertised on `idle_o` for the `dtmcs.idle` field.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock
- `rst_ni`  in  1  async active-low reset
- `dmi_capture_i`  in  1  capture-DR pulse for `dmi`
- `dmi_update_i`  in  1  update-DR pulse for `dmi`
- `dmi_wdata_i`  in  41  shifted-in value `{addr[6:0], data[31:0], op[1:0]}`
- `dmi_rdata_o`  out  41  capture value `{addr_q, data_q, status}`
- `dmireset_i`  in  1  pulse, clears the sticky error
- `dmihardreset_i`  in  1  pulse, aborts the transaction and clears the error
- `dmistat_o`  out  2  current sticky error (`dm::dmi_error_e`)
- `idle_o`  out  3  `IdleCycles`
- `dmi_req_valid_o`  out  1  request valid
- `dmi_req_ready_i`  in  1  request ready
- `dmi_req_o`  out  41  `dm::dmi_req_t`
- `dmi_resp_valid_i`  in  1  response valid
- `dmi_resp_ready_o`  out  1  response ready
- `dmi_resp_i`  in  34  `dm::dmi_resp_t`

## Operation
- Register reset values: `addr_q=0`, `data_q=0`, `error_q=DmiNoError`, `state_q=Idle`.
- Output reset values: `dmi_req_valid_o=0`, `dmi_resp_ready_o=1`.
- States: `Idle`, `Read`, `WaitReadValid`, `Write`, `WaitWriteValid`.
- `Idle`, on `dmi_update_i` with `error_q==DmiNoError`:
  - `op==DTM_READ`: latch addr, go to `Read`.
  - `op==DTM_WRITE`: latch addr and data, go to `Write`.
  - `op` NOP or 3: no request, state unchanged.
- `Idle`, on `dmi_update_i` with `error_q!=DmiNoError`: ignored.
- `Read`/`Write`: `dmi_req_valid_o=1`. `dmi_req_o` carries `addr_q`, the op, and `data_q` (zero data for reads); these fields are stable until the handshake. On `dmi_req_ready_i`, go to the matching Wait state.
- Wait states: `dmi_resp_ready_o=1`. On `dmi_resp_valid_i`:
  - In `WaitReadValid`, `data_q <= dmi_resp_i.data`.
  - In either Wait state, `resp!=DTM_SUCCESS` sets `error_q=DmiOpFailed`.
  - Return to `Idle`.
- In `Idle`, `dmi_resp_ready_o=1`, so stray responses are sunk and ignored. It is 0 in `Read`/`Write`.
- Busy is any state other than `Idle`. `dmi_update_i` or `dmi_capture_i` while busy sets `error_q=DmiBusy` if it is currently `DmiNoError`. An update while busy never starts a new request.
- `dmi_rdata_o` status field is `DmiBusy` if the controller is busy and no error is latched; otherwise it is `error_q`.
- `dmireset_i`: `error_q<=DmiNoError`. The state is not affected.
- `dmihardreset_i`: forces `Idle`, clears `error_q`, and drops `dmi_req_valid_o` next cycle (abort; the downstream DM is reset in parallel).
- Simultaneous events:
  - `dmihardreset_i` takes priority over everything.
  - `dmireset_i` with `dmi_update_i` in `Idle`: the error is cleared first, then the update is accepted.
  - A busy-error set in the same cycle as `dmireset_i`: the reset wins.

## Timing
- Update in `Idle` at cycle N: `dmi_req_valid_o=1` at N+1.
- Minimum round trip: request handshake at N+1, response at N+2, `Idle` at N+3. The next update is accepted at N+3.
- `dmi_rdata_o` and `dmistat_o` are combinational from registers; there are no input-to-output paths.
- `dmi_req_valid_o` never deasserts before `dmi_req_ready_i`, except on hardreset or rst_ni.

## Configuration
- `DMI_RESP_TIMEOUT_EN` defined:
  - An 8-bit counter runs in both Wait states.
  - If `dm::DmiTimeoutCycles` (255) cycles pass without `dmi_resp_valid_i`, set `error_q=DmiOpFailed`, return to `Idle`, and drop the later response.
  - The counter clears on entering a Wait state.
- `DMI_RESP_TIMEOUT_EN` undefined: the controller waits for a response indefinitely, and there is no counter logic.

## Structure
- Added to package `dm`:
  - `dmi_error_e` with `DmiNoError=0`, `DmiReserved=1`, `DmiOpFailed=2`, `DmiBusy=3`
  - `dmi_state_e` (the five states above)
  - `DmiTimeoutCycles`
- Reuses `dm::dmi_req_t`, `dm::dmi_resp_t`, `dm::dtm_op_e`, and `dm::DTM_SUCCESS`.
- Single module, with no sub-module. The timeout counter is inline under the macro.

## Test plan
- Read at `0x11`, DM responds with `data=0x0040_0382` and `resp=0`: one request with `op=DTM_READ` and `addr=0x11`. The next capture returns data `0x0040_0382` and status 0.
- Write `0x8000_0001` to `0x10`, with ready held low for 5 cycles: `valid` and the fields stay stable for 5 cycles, and exactly one handshake occurs.
- Update issued while in `WaitReadValid`: `dmistat_o=3`, and the later update with status 3 issues no request. After `dmireset_i`, `dmistat_o=0` and the next read succeeds.
- Response with `resp=2'h2` on a write: `dmistat_o=2` and sticky. The next update is ignored until `dmireset_i`.
- `dmihardreset_i` in `Read` with ready low: `valid=0` next cycle, `Idle`, `dmistat_o=0`.
- With `DMI_RESP_TIMEOUT_EN`: no response for 255 cycles means `dmistat_o=2` and `Idle`. A response arriving at cycle 300 is absorbed, and `data_q` is unchanged.
